uart_sample_rx: RTL and testbench
=================================

Name: uart_sample_rx

Overview:
Receiving end of the board's UART sample-telemetry link, so one FPGA can ingest another's ADC stream or a host can loop samples back.
- Deserialises 8N1 UART bytes and parses 5-byte frames: 'C', 'H', ASCII channel id '0'..'3', sample MSB, sample LSB.
- Holds the last received 16-bit sample per channel and pulses a strobe on each completed frame.
- Sits between a pin-level RX input and sample-domain logic: the same sample_outN bus shape the codec and DSP blocks use.

Parameters:
- CLK_FREQ, 12_000_000, system clock frequency in Hz.
- BAUD, 115200, line rate. DIV = CLK_FREQ/BAUD (integer division, 104 at defaults). HALF = DIV/2 (52).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rx  in  1  UART serial input, idle high, asynchronous to clk.
- byte_valid  out  1  one-cycle pulse: byte_data holds a good received byte.
- byte_data  out  8  last good received byte.
- sample_out0..sample_out3  out  16 each  last committed sample per channel, two's complement {MSB,LSB}.
- sample_valid  out  1  one-cycle pulse on frame commit.
- sample_ch  out  2  channel of the most recent commit.
- err_count  out  8  saturating count of framing and protocol errors.
- seq_err  out  1  one-cycle pulse on a channel-order violation; present only with the optional feature.

Behaviour:
- Reset values:
  - all outputs 0; byte_data, sample_outN, sample_ch and err_count all 0.
  - rx synchroniser flops reset to 1; both FSMs in their idle states.
- Reset is honoured mid-byte or mid-frame: any partial byte or frame is discarded.
- rx passes a 2-flop synchroniser. Timing below refers to the synchronised signal rxs.
- Bit FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: on a 1->0 transition of rxs, go to START and clear the bit counter.
  - START: after HALF cycles, sample rxs. If 1 (glitch), return to IDLE with no error. If 0, go to DATA.
  - DATA: sample every DIV cycles, LSB first, 8 bits, then go to STOP.
  - STOP: after DIV cycles, sample rxs.
    - If 1: set byte_data and pulse byte_valid in that same cycle, return to IDLE.
    - If 0: framing error. Increment err_count, signal abort to the parser, go to WAIT_IDLE.
  - WAIT_IDLE: stay until rxs = 1, then go to IDLE. A held-low break is a single error.
- Frame parser states: HUNT, GOT_C, GOT_H, GET_MSB, GET_LSB. It advances only on byte_valid.
  - HUNT: 'C' (0x43) -> GOT_C; any other byte stays in HUNT.
  - GOT_C: 'H' -> GOT_H; 'C' -> GOT_C; else -> HUNT.
  - GOT_H:
    - 0x30..0x33: latch ch = byte - 0x30, go to GET_MSB.
    - 'C': err_count++ and go to GOT_C.
    - Any other byte: err_count++ and go to HUNT.
  - GET_MSB: latch any byte value as msb (0x43 included), go to GET_LSB.
  - GET_LSB: go to HUNT. On the next clk edge:
    - sample_out[ch] <= {msb, byte};
    - sample_ch <= ch;
    - sample_valid pulses high for exactly that one cycle.
  - Latency: sample_valid rises 1 cycle after the byte_valid of the LSB.
- A framing-error abort returns the parser to HUNT from any state. The in-progress frame is not committed.
- Untouched channels keep their previous values.
- err_count saturates at 255.
  - A framing error and a protocol error never occur in the same cycle, so err_count increments by 1 per cycle at most.

Optional Feature:
UART_SAMPLE_RX_SEQ_CHECK_EN
- With the macro defined:
  - The block tracks the last committed channel.
  - A commit whose ch is not (last + 1) mod 4 pulses seq_err in the same cycle as sample_valid.
  - The out-of-order sample is still committed.
  - The first commit after reset never flags.
  - seq_err does not affect err_count.
- Without the macro: the seq_err port and the tracking logic are absent.

Test Plan:
- Bytes 'C','H','2',0x12,0x34 at 115200 -> sample_out2 = 0x1234; sample_valid pulses one cycle with sample_ch = 2; other channels stay 0; err_count = 0.
- Bytes 'X','C','C','H','1',0xFF,0x80 -> sample_out1 = 0xFF80 (negative); exactly one sample_valid; err_count = 0.
- Bytes 'C','H','7',0x11,0x22 -> no commit; err_count = 1; a following valid 'C','H','0',0x00,0x05 frame gives sample_out0 = 0x0005.
- 'C','H','3', then an MSB byte with stop bit driven 0, then a valid frame for ch3 with 0xABCD -> err_count = 1; first frame discarded; sample_out3 = 0xABCD.
- 30-cycle low glitch on rx -> no byte_valid, no error. rst_n asserted during GET_LSB -> no commit and all outputs 0; a subsequent frame decodes normally.
- (UART_SAMPLE_RX_SEQ_CHECK_EN) Frames for channels 0,1,3 -> seq_err pulses only on the ch3 commit; sample_out3 is updated.

Source files
------------

// File: rtl/uart_sample_rx_if.sv
// rtl/uart_sample_rx_if.sv - pin/sample-side signal bundle for uart_sample_rx
// Purpose: groups the serial input and the byte/sample/error outputs of uart_sample_rx.
// Signals:
//   rx            serial input, idle high (driven by the slave side)
//   byte_valid    one-cycle strobe, byte_data holds a good received byte
//   byte_data     last good received byte
//   sample_out0..3 last committed 16-bit sample per channel
//   sample_valid  one-cycle strobe on frame commit
//   sample_ch     channel of the most recent commit
//   err_count     saturating framing/protocol error count
//   seq_err       channel-order violation strobe (only with UART_SAMPLE_RX_SEQ_CHECK_EN)
// Modports: master = receiver block, slave = consumer / line driver.
interface uart_sample_rx_if;
    logic        rx;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic [15:0] sample_out0;
    logic [15:0] sample_out1;
    logic [15:0] sample_out2;
    logic [15:0] sample_out3;
    logic        sample_valid;
    logic [1:0]  sample_ch;
    logic [7:0]  err_count;
`ifdef UART_SAMPLE_RX_SEQ_CHECK_EN
    logic        seq_err;
`endif

    modport master (
`ifdef UART_SAMPLE_RX_SEQ_CHECK_EN
        output seq_err,
`endif
        input  rx,
        output byte_valid, byte_data,
        output sample_out0, sample_out1, sample_out2, sample_out3,
        output sample_valid, sample_ch, err_count
    );

    modport slave (
`ifdef UART_SAMPLE_RX_SEQ_CHECK_EN
        input  seq_err,
`endif
        output rx,
        input  byte_valid, byte_data,
        input  sample_out0, sample_out1, sample_out2, sample_out3,
        input  sample_valid, sample_ch, err_count
    );
endinterface

// File: rtl/uart_sample_rx.sv
// rtl/uart_sample_rx.sv - 8N1 UART receiver with 'C','H',<ch>,<msb>,<lsb> sample frame parser
// Purpose: deserialises UART bytes, parses 5-byte sample frames and holds the last
//          16-bit sample per channel (0..3), with a commit strobe and an error counter.
// Parameters: CLK_FREQ (Hz), BAUD; bit period DIV = CLK_FREQ/BAUD, mid-start offset HALF = DIV/2.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    uart_sample_rx_if.master (rx in; byte/sample/error outputs)
// Optional build macro: UART_SAMPLE_RX_SEQ_CHECK_EN adds channel-order tracking and seq_err.
module uart_sample_rx #(
    parameter int CLK_FREQ = 12_000_000,
    parameter int BAUD     = 115_200
) (
    input  logic             clk,
    input  logic             rst_n,
    uart_sample_rx_if.master bus
);
    localparam int DIV  = CLK_FREQ / BAUD;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV + 1);
    localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);

    // ------------------------------------------------------------------
    // rx synchroniser; the extra stage gives the previous value for
    // falling-edge detection. All reset to the idle (high) line level.
    // ------------------------------------------------------------------
    logic rx_meta_q, rxs_q, rxs_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q  <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
        end else begin
            rx_meta_q  <= bus.rx;
            rxs_q      <= rx_meta_q;
            rxs_prev_q <= rxs_q;
        end
    end

    // ------------------------------------------------------------------
    // Bit FSM
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        B_IDLE,
        B_START,
        B_DATA,
        B_STOP,
        B_WAIT_IDLE
    } bit_state_t;

    bit_state_t    bit_state_q, bit_state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    byte_data_q, byte_data_d;
    logic          byte_valid_q, byte_valid_d;
    logic          tick;
    logic          sample_bit;
    logic          byte_ok;
    logic          frame_err;

    // START waits half a bit to land mid start-bit; every later sample is a full bit apart.
    assign tick = (cnt_q == ((bit_state_q == B_START) ? HALF_M1 : DIV_M1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_state_q <= B_IDLE;
        end else begin
            bit_state_q <= bit_state_d;
        end
    end

    always_comb begin
        bit_state_d = bit_state_q;
        case (bit_state_q)
            B_IDLE: begin
                if (rxs_prev_q && !rxs_q) begin
                    bit_state_d = B_START;
                end
            end
            B_START: begin
                if (tick) begin
                    bit_state_d = rxs_q ? B_IDLE : B_DATA;
                end
            end
            B_DATA: begin
                if (tick && (bit_cnt_q == 3'd7)) begin
                    bit_state_d = B_STOP;
                end
            end
            B_STOP: begin
                if (tick) begin
                    bit_state_d = rxs_q ? B_IDLE : B_WAIT_IDLE;
                end
            end
            B_WAIT_IDLE: begin
                if (rxs_q) begin
                    bit_state_d = B_IDLE;
                end
            end
            default: bit_state_d = B_IDLE;
        endcase
    end

    always_comb begin
        sample_bit = 1'b0;
        byte_ok    = 1'b0;
        frame_err  = 1'b0;
        case (bit_state_q)
            B_DATA: sample_bit = tick;
            B_STOP: begin
                byte_ok   = tick & rxs_q;
                frame_err = tick & ~rxs_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        if ((bit_state_q == B_START || bit_state_q == B_DATA || bit_state_q == B_STOP) && !tick) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = '0;
        end
        bit_cnt_d    = (bit_state_q == B_IDLE) ? 3'd0 : bit_cnt_q + {2'b00, sample_bit};
        shift_d      = sample_bit ? {rxs_q, shift_q[7:1]} : shift_q;
        byte_data_d  = byte_ok ? shift_q : byte_data_q;
        byte_valid_d = byte_ok;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            byte_data_q  <= 8'h00;
            byte_valid_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            byte_data_q  <= byte_data_d;
            byte_valid_q <= byte_valid_d;
        end
    end

    // ------------------------------------------------------------------
    // Frame parser FSM, stepped by byte_valid_q; a framing error aborts it.
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        P_HUNT,
        P_GOT_C,
        P_GOT_H,
        P_GET_MSB,
        P_GET_LSB
    } par_state_t;

    localparam logic [7:0] CHAR_C = 8'h43;
    localparam logic [7:0] CHAR_H = 8'h48;

    par_state_t  par_q, par_d;
    logic        is_ch;
    logic        ch_load;
    logic        msb_load;
    logic        commit;
    logic        proto_err;
    logic [1:0]  ch_q, ch_d;
    logic [7:0]  msb_q, msb_d;
    logic [15:0] sample_q [4];
    logic [1:0]  sample_ch_q;
    logic        sample_valid_q;
    logic [7:0]  err_q;

    // '0'..'3' are 0x30..0x33: upper six bits fixed, low two bits are the channel.
    assign is_ch = (byte_data_q[7:2] == 6'b001100);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q <= P_HUNT;
        end else begin
            par_q <= par_d;
        end
    end

    always_comb begin
        par_d = par_q;
        if (frame_err) begin
            par_d = P_HUNT;
        end else if (byte_valid_q) begin
            case (par_q)
                P_HUNT:    par_d = (byte_data_q == CHAR_C) ? P_GOT_C : P_HUNT;
                P_GOT_C: begin
                    if (byte_data_q == CHAR_H) begin
                        par_d = P_GOT_H;
                    end else if (byte_data_q == CHAR_C) begin
                        par_d = P_GOT_C;
                    end else begin
                        par_d = P_HUNT;
                    end
                end
                P_GOT_H: begin
                    if (is_ch) begin
                        par_d = P_GET_MSB;
                    end else if (byte_data_q == CHAR_C) begin
                        par_d = P_GOT_C;
                    end else begin
                        par_d = P_HUNT;
                    end
                end
                P_GET_MSB: par_d = P_GET_LSB;
                P_GET_LSB: par_d = P_HUNT;
                default:   par_d = P_HUNT;
            endcase
        end
    end

    always_comb begin
        ch_load   = 1'b0;
        msb_load  = 1'b0;
        commit    = 1'b0;
        proto_err = 1'b0;
        if (byte_valid_q && !frame_err) begin
            case (par_q)
                P_GOT_H: begin
                    ch_load   = is_ch;
                    proto_err = ~is_ch;
                end
                P_GET_MSB: msb_load = 1'b1;
                P_GET_LSB: commit   = 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        ch_d  = ch_load ? byte_data_q[1:0] : ch_q;
        msb_d = msb_load ? byte_data_q : msb_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_q           <= 2'd0;
            msb_q          <= 8'h00;
            sample_ch_q    <= 2'd0;
            sample_valid_q <= 1'b0;
            err_q          <= 8'h00;
            for (int i = 0; i < 4; i++) begin
                sample_q[i] <= 16'h0000;
            end
        end else begin
            ch_q           <= ch_d;
            msb_q          <= msb_d;
            sample_valid_q <= commit;
            if (commit) begin
                sample_q[ch_q] <= {msb_q, byte_data_q};
                sample_ch_q    <= ch_q;
            end
            // Framing and protocol errors are mutually exclusive in time, so +1 suffices.
            if ((frame_err || proto_err) && (err_q != 8'hFF)) begin
                err_q <= err_q + 8'd1;
            end
        end
    end

`ifdef UART_SAMPLE_RX_SEQ_CHECK_EN
    // Channel-order check: each commit should follow the previous channel mod 4.
    logic [1:0] last_ch_q;
    logic       have_last_q;
    logic       seq_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_ch_q   <= 2'd0;
            have_last_q <= 1'b0;
            seq_err_q   <= 1'b0;
        end else begin
            seq_err_q <= commit && have_last_q && (ch_q != (last_ch_q + 2'd1));
            if (commit) begin
                last_ch_q   <= ch_q;
                have_last_q <= 1'b1;
            end
        end
    end

    assign bus.seq_err = seq_err_q;
`endif

    assign bus.byte_valid   = byte_valid_q;
    assign bus.byte_data    = byte_data_q;
    assign bus.sample_out0  = sample_q[0];
    assign bus.sample_out1  = sample_q[1];
    assign bus.sample_out2  = sample_q[2];
    assign bus.sample_out3  = sample_q[3];
    assign bus.sample_valid = sample_valid_q;
    assign bus.sample_ch    = sample_ch_q;
    assign bus.err_count    = err_q;
endmodule

// File: tb/tb_uart_sample_rx.sv
// tb/tb_uart_sample_rx.sv - self-checking bench for uart_sample_rx against a frame-level model
`timescale 1ns/1ps
module tb_uart_sample_rx;
    localparam int CLK_FREQ = 12_000_000;
    localparam int BAUD     = 115_200;
    localparam int DIV      = CLK_FREQ / BAUD;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_sample_rx_if bus ();

    uart_sample_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [1:0]  ch;
        logic [15:0] val;
        logic        seq;
    } commit_t;

    logic seq_sig;
`ifdef UART_SAMPLE_RX_SEQ_CHECK_EN
    assign seq_sig = bus.seq_err;
`else
    assign seq_sig = 1'b0;
`endif

    function automatic logic [15:0] dut_s(input int c);
        case (c)
            0:       return bus.sample_out0;
            1:       return bus.sample_out1;
            2:       return bus.sample_out2;
            default: return bus.sample_out3;
        endcase
    endfunction

    // Monitor: records what the DUT reports, sampled on the falling edge.
    commit_t    mon_c[$];
    logic [7:0] mon_b[$];
    int         sv_wide   = 0;
    int         seq_stray = 0;
    logic       sv_prev   = 1'b0;

    always @(negedge clk) begin
        if (bus.sample_valid === 1'b1)
            mon_c.push_back('{ch: bus.sample_ch, val: dut_s(int'(bus.sample_ch)), seq: seq_sig});
        if (bus.sample_valid === 1'b1 && sv_prev === 1'b1) sv_wide++;
        if (seq_sig === 1'b1 && bus.sample_valid !== 1'b1) seq_stray++;
        sv_prev = bus.sample_valid;
        if (bus.byte_valid === 1'b1) mon_b.push_back(bus.byte_data);
    end

    // Reference model: consumes whole bytes, tracks position within a frame.
    int          m_pos;
    logic [1:0]  m_ch;
    logic [7:0]  m_msb;
    logic [15:0] m_s[4];
    int          m_err;
    int          m_last;
    commit_t     m_c[$];
    logic [7:0]  m_b[$];

    function automatic void model_reset();
        m_pos  = 0;
        m_err  = 0;
        m_last = -1;
        for (int i = 0; i < 4; i++) m_s[i] = 16'h0;
    endfunction

    function automatic void model_byte(input logic [7:0] b, input bit bad);
        logic sq;
        if (bad) begin
            if (m_err < 255) m_err++;
            m_pos = 0;
            return;
        end
        m_b.push_back(b);
        case (m_pos)
            0: m_pos = (b == "C") ? 1 : 0;
            1: m_pos = (b == "H") ? 2 : ((b == "C") ? 1 : 0);
            2: begin
                if (b >= 8'h30 && b <= 8'h33) begin
                    m_ch  = 2'(b - 8'h30);
                    m_pos = 3;
                end else begin
                    if (m_err < 255) m_err++;
                    m_pos = (b == "C") ? 1 : 0;
                end
            end
            3: begin
                m_msb = b;
                m_pos = 4;
            end
            default: begin
`ifdef UART_SAMPLE_RX_SEQ_CHECK_EN
                sq = (m_last >= 0) && (int'(m_ch) != (m_last + 1) % 4);
`else
                sq = 1'b0;
`endif
                m_s[m_ch] = {m_msb, b};
                m_c.push_back('{ch: m_ch, val: {m_msb, b}, seq: sq});
                m_last = int'(m_ch);
                m_pos  = 0;
            end
        endcase
    endfunction

    function automatic int commit_diffs();
        int n = (mon_c.size() > m_c.size()) ? mon_c.size() : m_c.size();
        int d = 0;
        for (int i = 0; i < n; i++)
            if (i >= mon_c.size() || i >= m_c.size() || mon_c[i] !== m_c[i]) d++;
        return d;
    endfunction

    function automatic int byte_diffs();
        int n = (mon_b.size() > m_b.size()) ? mon_b.size() : m_b.size();
        int d = 0;
        for (int i = 0; i < n; i++)
            if (i >= mon_b.size() || i >= m_b.size() || mon_b[i] !== m_b[i]) d++;
        return d;
    endfunction

    task automatic start_test();
        mon_c.delete();
        m_c.delete();
        mon_b.delete();
        m_b.delete();
        sv_wide   = 0;
        seq_stray = 0;
    endtask

    // Drive one 8N1 byte; bad=1 drives the stop bit low then returns the line high.
    task automatic send_byte(input logic [7:0] b, input bit bad);
        bus.rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            repeat (DIV) @(negedge clk);
        end
        bus.rx = bad ? 1'b0 : 1'b1;
        repeat (DIV) @(negedge clk);
        bus.rx = 1'b1;
        if (bad) repeat (DIV) @(negedge clk);
        repeat ($urandom_range(1, 12)) @(negedge clk);
        model_byte(b, bad);
    endtask

    task automatic send_frame(input int ch, input logic [15:0] v);
        send_byte("C", 1'b0);
        send_byte("H", 1'b0);
        send_byte(8'h30 + 8'(ch), 1'b0);
        send_byte(v[15:8], 1'b0);
        send_byte(v[7:0], 1'b0);
    endtask

    task automatic pulse_reset();
        rst_n  = 1'b0;
        bus.rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        bus.rx = 1'b1;
        rst_n  = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        checks++; if (bus.byte_valid !== 1'b0) begin failures++; $display("FAIL reset_byte_valid got=%b exp=0", bus.byte_valid); end
        checks++; if (bus.byte_data !== 8'h00) begin failures++; $display("FAIL reset_byte_data got=%h exp=00", bus.byte_data); end
        checks++; if (bus.sample_valid !== 1'b0) begin failures++; $display("FAIL reset_sample_valid got=%b exp=0", bus.sample_valid); end
        checks++; if (bus.sample_ch !== 2'd0) begin failures++; $display("FAIL reset_sample_ch got=%0d exp=0", bus.sample_ch); end
        checks++; if (bus.err_count !== 8'h00) begin failures++; $display("FAIL reset_err_count got=%0d exp=0", bus.err_count); end
        for (int c = 0; c < 4; c++) begin
            checks++; if (dut_s(c) !== 16'h0) begin failures++; $display("FAIL reset_out%0d got=%h exp=0000", c, dut_s(c)); end
        end
        checks++; if (seq_sig !== 1'b0) begin failures++; $display("FAIL reset_seq_err got=%b exp=0", seq_sig); end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_basic();
        start_test();
        send_frame(2, 16'h1234);
        checks++; if (bus.sample_out2 !== 16'h1234) begin failures++; $display("FAIL basic_out2 got=%h exp=1234", bus.sample_out2); end
        checks++; if (mon_c.size() !== 1 || mon_c[0].ch !== 2'd2) begin failures++; $display("FAIL basic_commit got_n=%0d exp_n=1 exp_ch=2", mon_c.size()); end
        checks++; if (bus.err_count !== 8'd0) begin failures++; $display("FAIL basic_err got=%0d exp=0", bus.err_count); end
        for (int c = 0; c < 4; c++) begin
            checks++; if (dut_s(c) !== m_s[c]) begin failures++; $display("FAIL basic_out%0d got=%h exp=%h", c, dut_s(c), m_s[c]); end
        end
        checks++; if (commit_diffs() != 0 || byte_diffs() != 0 || sv_wide != 0) begin failures++; $display("FAIL basic_stream got_commits=%0d exp=%0d byte_diffs=%0d wide=%0d", mon_c.size(), m_c.size(), byte_diffs(), sv_wide); end
    endtask

    task automatic test_hunt();
        start_test();
        send_byte("X", 1'b0);
        send_byte("C", 1'b0);
        send_frame(1, 16'hFF80);
        checks++; if (bus.sample_out1 !== 16'hFF80) begin failures++; $display("FAIL hunt_out1 got=%h exp=ff80", bus.sample_out1); end
        checks++; if (mon_c.size() !== 1) begin failures++; $display("FAIL hunt_commits got=%0d exp=1", mon_c.size()); end
        checks++; if (bus.err_count !== 8'(m_err)) begin failures++; $display("FAIL hunt_err got=%0d exp=%0d", bus.err_count, m_err); end
        for (int c = 0; c < 4; c++) begin
            checks++; if (dut_s(c) !== m_s[c]) begin failures++; $display("FAIL hunt_out%0d got=%h exp=%h", c, dut_s(c), m_s[c]); end
        end
        checks++; if (commit_diffs() != 0 || byte_diffs() != 0 || sv_wide != 0) begin failures++; $display("FAIL hunt_stream got_commits=%0d exp=%0d byte_diffs=%0d wide=%0d", mon_c.size(), m_c.size(), byte_diffs(), sv_wide); end
    endtask

    task automatic test_bad_channel();
        int e0;
        start_test();
        e0 = m_err;
        send_byte("C", 1'b0);
        send_byte("H", 1'b0);
        send_byte("7", 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        checks++; if (mon_c.size() !== 0) begin failures++; $display("FAIL badch_commits got=%0d exp=0", mon_c.size()); end
        checks++; if (bus.err_count !== 8'(e0 + 1)) begin failures++; $display("FAIL badch_err got=%0d exp=%0d", bus.err_count, e0 + 1); end
        send_frame(0, 16'h0005);
        checks++; if (bus.sample_out0 !== 16'h0005) begin failures++; $display("FAIL badch_out0 got=%h exp=0005", bus.sample_out0); end
        for (int c = 0; c < 4; c++) begin
            checks++; if (dut_s(c) !== m_s[c]) begin failures++; $display("FAIL badch_out%0d got=%h exp=%h", c, dut_s(c), m_s[c]); end
        end
        checks++; if (commit_diffs() != 0 || byte_diffs() != 0 || sv_wide != 0) begin failures++; $display("FAIL badch_stream got_commits=%0d exp=%0d byte_diffs=%0d wide=%0d", mon_c.size(), m_c.size(), byte_diffs(), sv_wide); end
    endtask

    task automatic test_framing();
        int e0;
        start_test();
        e0 = m_err;
        send_byte("C", 1'b0);
        send_byte("H", 1'b0);
        send_byte("3", 1'b0);
        send_byte(8'h99, 1'b1);
        send_frame(3, 16'hABCD);
        checks++; if (bus.err_count !== 8'(e0 + 1)) begin failures++; $display("FAIL frame_err got=%0d exp=%0d", bus.err_count, e0 + 1); end
        checks++; if (bus.sample_out3 !== 16'hABCD) begin failures++; $display("FAIL frame_out3 got=%h exp=abcd", bus.sample_out3); end
        checks++; if (mon_c.size() !== 1) begin failures++; $display("FAIL frame_commits got=%0d exp=1", mon_c.size()); end
        for (int c = 0; c < 4; c++) begin
            checks++; if (dut_s(c) !== m_s[c]) begin failures++; $display("FAIL frame_out%0d got=%h exp=%h", c, dut_s(c), m_s[c]); end
        end
        checks++; if (commit_diffs() != 0 || byte_diffs() != 0 || sv_wide != 0) begin failures++; $display("FAIL frame_stream got_commits=%0d exp=%0d byte_diffs=%0d wide=%0d", mon_c.size(), m_c.size(), byte_diffs(), sv_wide); end
    endtask

    task automatic test_glitch();
        start_test();
        bus.rx = 1'b0;
        repeat (30) @(negedge clk);
        bus.rx = 1'b1;
        repeat (3 * DIV) @(negedge clk);
        checks++; if (mon_b.size() !== 0) begin failures++; $display("FAIL glitch_bytes got=%0d exp=0", mon_b.size()); end
        checks++; if (bus.err_count !== 8'(m_err)) begin failures++; $display("FAIL glitch_err got=%0d exp=%0d", bus.err_count, m_err); end
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] v;
        start_test();
        send_byte("C", 1'b0);
        send_byte("H", 1'b0);
        send_byte("0", 1'b0);
        send_byte(8'h55, 1'b0);
        bus.rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            bus.rx = i[0];
            repeat (DIV) @(negedge clk);
        end
        repeat (DIV / 2) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (mon_c.size() !== 0) begin failures++; $display("FAIL rstmid_commits got=%0d exp=0", mon_c.size()); end
        checks++; if (bus.err_count !== 8'h00 || bus.byte_data !== 8'h00 || bus.sample_ch !== 2'd0) begin failures++; $display("FAIL rstmid_regs got_err=%0d got_byte=%h got_ch=%0d exp=0", bus.err_count, bus.byte_data, bus.sample_ch); end
        for (int c = 0; c < 4; c++) begin
            checks++; if (dut_s(c) !== 16'h0) begin failures++; $display("FAIL rstmid_out%0d got=%h exp=0000", c, dut_s(c)); end
        end
        bus.rx = 1'b1;
        model_reset();
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * DIV) @(negedge clk);
        checks++; if (mon_c.size() !== 0 || bus.sample_out0 !== 16'h0) begin failures++; $display("FAIL rstmid_after got_commits=%0d got_out0=%h exp=0", mon_c.size(), bus.sample_out0); end
        start_test();
        v = 16'($urandom);
        send_frame(1, v);
        checks++; if (bus.sample_out1 !== v) begin failures++; $display("FAIL rstmid_out1 got=%h exp=%h", bus.sample_out1, v); end
        checks++; if (commit_diffs() != 0 || byte_diffs() != 0 || sv_wide != 0) begin failures++; $display("FAIL rstmid_stream got_commits=%0d exp=%0d byte_diffs=%0d wide=%0d", mon_c.size(), m_c.size(), byte_diffs(), sv_wide); end
    endtask

    task automatic test_random();
        start_test();
        for (int it = 0; it < 2; it++) begin
            send_byte(8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0));
            send_frame($urandom_range(0, 3), 16'($urandom));
        end
        checks++; if (bus.err_count !== 8'(m_err)) begin failures++; $display("FAIL random_err got=%0d exp=%0d", bus.err_count, m_err); end
        for (int c = 0; c < 4; c++) begin
            checks++; if (dut_s(c) !== m_s[c]) begin failures++; $display("FAIL random_out%0d got=%h exp=%h", c, dut_s(c), m_s[c]); end
        end
        checks++; if (commit_diffs() != 0 || byte_diffs() != 0 || sv_wide != 0) begin failures++; $display("FAIL random_stream got_commits=%0d exp=%0d byte_diffs=%0d wide=%0d", mon_c.size(), m_c.size(), byte_diffs(), sv_wide); end
    endtask

`ifdef UART_SAMPLE_RX_SEQ_CHECK_EN
    task automatic test_seq();
        logic [15:0] v3;
        pulse_reset();
        start_test();
        v3 = 16'($urandom);
        send_frame(0, 16'($urandom));
        send_frame(1, 16'($urandom));
        send_frame(3, v3);
        checks++; if (mon_c.size() !== 3 || mon_c[0].seq !== 1'b0 || mon_c[1].seq !== 1'b0 || mon_c[2].seq !== 1'b1) begin failures++; $display("FAIL seq_flags got_n=%0d got=%b%b%b exp=001", mon_c.size(), mon_c[0].seq, mon_c[1].seq, mon_c[2].seq); end
        checks++; if (bus.sample_out3 !== v3) begin failures++; $display("FAIL seq_out3 got=%h exp=%h", bus.sample_out3, v3); end
        checks++; if (seq_stray != 0 || bus.err_count !== 8'(m_err)) begin failures++; $display("FAIL seq_side got_stray=%0d got_err=%0d exp_err=%0d", seq_stray, bus.err_count, m_err); end
        checks++; if (commit_diffs() != 0) begin failures++; $display("FAIL seq_stream got_commits=%0d exp=%0d", mon_c.size(), m_c.size()); end
    endtask
`endif

    initial begin
        #3_000_000;
        $display("FAIL timeout simulation exceeded its time bound");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    initial begin
        bus.rx = 1'b1;
        test_reset();
        test_basic();
        test_hunt();
        test_bad_channel();
        test_framing();
        test_glitch();
        test_reset_mid_frame();
        test_random();
`ifdef UART_SAMPLE_RX_SEQ_CHECK_EN
        test_seq();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
